// File: rtl/vram_read_arbiter_if.sv
// Read-port bundle between the two requesters, the arbiter and the image RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface vram_read_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              i_a_req;
  logic [ADDR_W-1:0] i_a_addr;
  logic              o_a_gnt;
  logic              o_a_valid;
  logic [DATA_W-1:0] o_a_data;
  logic              i_b_req;
  logic [ADDR_W-1:0] i_b_addr;
  logic              o_b_gnt;
  logic              o_b_valid;
  logic [DATA_W-1:0] o_b_data;
  logic [ADDR_W-1:0] o_addrb;
  logic [DATA_W-1:0] i_doutb;
  logic              o_starved;

  modport slave (
    input  i_a_req, i_a_addr, i_b_req, i_b_addr, i_doutb,
    output o_a_gnt, o_a_valid, o_a_data, o_b_gnt, o_b_valid, o_b_data,
           o_addrb, o_starved
  );

  modport master (
    output i_a_req, i_a_addr, i_b_req, i_b_addr, i_doutb,
    input  o_a_gnt, o_a_valid, o_a_data, o_b_gnt, o_b_valid, o_b_data,
           o_addrb, o_starved
  );
endinterface

// File: rtl/vram_read_arbiter.sv
// Two-port arbiter onto the single image-RAM read port: A (pixel fetch) has
// priority, B gets a forced grant after STARVE_MAX denied cycles.
module vram_read_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  vram_read_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic vld;
    logic is_b;
  } tag_t;

  logic [CNT_W-1:0] starve_cnt;
  tag_t [RD_LAT:0]  vld_pipe;
  tag_t             new_tag;
  logic             force_b;
  logic             a_xfer;
  logic             b_xfer;

  assign force_b     = bus.i_b_req && (starve_cnt == CNT_W'(STARVE_MAX));
  assign bus.o_b_gnt = ~i_rst & bus.i_b_req & (~bus.i_a_req | force_b);
  assign bus.o_a_gnt = ~i_rst & bus.i_a_req & ~force_b;
  assign a_xfer      = bus.o_a_gnt;
  assign b_xfer      = bus.o_b_gnt;
  assign new_tag     = '{vld: a_xfer | b_xfer, is_b: b_xfer};

  // Tag at slot RD_LAT marks the edge where i_doutb holds that read's data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt    <= '0;
      vld_pipe      <= '0;
      bus.o_addrb   <= '0;
      bus.o_starved <= 1'b0;
      bus.o_a_valid <= 1'b0;
      bus.o_b_valid <= 1'b0;
      bus.o_a_data  <= '0;
      bus.o_b_data  <= '0;
    end else begin
      vld_pipe      <= {vld_pipe[RD_LAT-1:0], new_tag};
      bus.o_starved <= b_xfer & force_b;

      if (a_xfer)      bus.o_addrb <= bus.i_a_addr;
      else if (b_xfer) bus.o_addrb <= bus.i_b_addr;

      if (!bus.i_b_req || b_xfer) starve_cnt <= '0;
      else                        starve_cnt <= starve_cnt + CNT_W'(1);

      bus.o_a_valid <= vld_pipe[RD_LAT].vld & ~vld_pipe[RD_LAT].is_b;
      bus.o_b_valid <= vld_pipe[RD_LAT].vld &  vld_pipe[RD_LAT].is_b;
      if (vld_pipe[RD_LAT].vld && !vld_pipe[RD_LAT].is_b) bus.o_a_data <= bus.i_doutb;
      if (vld_pipe[RD_LAT].vld &&  vld_pipe[RD_LAT].is_b) bus.o_b_data <= bus.i_doutb;
    end
  end
endmodule

// File: tb/tb_vram_read_arbiter.sv
// Directed + random bench for vram_read_arbiter against a queue-based model
// of outstanding reads and a synchronous RAM with RD_LAT read latency.
module tb_vram_read_arbiter;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  function automatic logic [DATA_W-1:0] ram_f(input logic [ADDR_W-1:0] a);
    if (a == 15'h0010) return 16'hABCD;
    return {a[7:0], a[14:7]} ^ 16'h3C5A;
  endfunction

  logic [DATA_W-1:0] dq [RD_LAT];
  always @(posedge clk) begin
    dq[0] <= ram_f(bus.o_addrb);
    for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
  end
  assign bus.i_doutb = dq[RD_LAT-1];

  typedef struct {
    int               due;
    bit               is_b;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  rd_t               q[$];
  int                edge_n = 0;
  int                cnt = 0;
  bit                e_a_valid, e_b_valid, e_starved;
  logic [DATA_W-1:0] e_a_data, e_b_data;
  logic [ADDR_W-1:0] e_addrb;
  int                ntests = 0, nfail = 0;
  int                n_b_gnt = 0, n_starved = 0, n_b_valid = 0, n_a_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check gnts, advance model at posedge, check registers.
  task automatic step(input bit r, input bit ar, input logic [ADDR_W-1:0] aa,
                      input bit br, input logic [ADDR_W-1:0] ba);
    bit fb, ga, gb;
    rd_t t;
    rst = r;
    bus.i_a_req = ar; bus.i_a_addr = aa;
    bus.i_b_req = br; bus.i_b_addr = ba;
    #1;
    fb = br && (cnt == STARVE_MAX);
    gb = !r && br && (!ar || fb);
    ga = !r && ar && !fb;
    chk("a_gnt", 32'(bus.o_a_gnt), 32'(ga));
    chk("b_gnt", 32'(bus.o_b_gnt), 32'(gb));
    chk("gnt_excl", 32'(bus.o_a_gnt & bus.o_b_gnt), 32'd0);
    n_b_gnt += int'(bus.o_b_gnt);
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt = 0; e_a_valid = 0; e_b_valid = 0; e_starved = 0;
      e_a_data = '0; e_b_data = '0; e_addrb = '0;
    end else begin
      e_a_valid = 0; e_b_valid = 0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        t = q.pop_front();
        if (t.is_b) begin e_b_valid = 1; e_b_data = ram_f(t.addr); end
        else        begin e_a_valid = 1; e_a_data = ram_f(t.addr); end
      end
      if (ga) begin q.push_back('{edge_n + RD_LAT + 1, 1'b0, aa}); e_addrb = aa; end
      if (gb) begin q.push_back('{edge_n + RD_LAT + 1, 1'b1, ba}); e_addrb = ba; end
      e_starved = gb && fb;
      cnt = (!br || gb) ? 0 : cnt + 1;
    end
    edge_n++;
    @(negedge clk);
    chk("a_valid", 32'(bus.o_a_valid), 32'(e_a_valid));
    chk("b_valid", 32'(bus.o_b_valid), 32'(e_b_valid));
    chk("a_data", 32'(bus.o_a_data), 32'(e_a_data));
    chk("b_data", 32'(bus.o_b_data), 32'(e_b_data));
    chk("addrb", 32'(bus.o_addrb), 32'(e_addrb));
    chk("starved", 32'(bus.o_starved), 32'(e_starved));
    chk("valid_excl", 32'(bus.o_a_valid & bus.o_b_valid), 32'd0);
    n_starved += int'(bus.o_starved);
    n_b_valid += int'(bus.o_b_valid);
    n_a_valid += int'(bus.o_a_valid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_a_req = 0; bus.i_a_addr = '0; bus.i_b_req = 0; bus.i_b_addr = '0;
    @(negedge clk);
    step(1, 0, '0, 0, '0);
    step(1, 1, 15'h5, 1, 15'h6);

    // single A read of 0xABCD at 0x0010
    step(0, 1, 15'h0010, 0, '0);
    idle(4);
    chk("t1_a_valid_cnt", 32'(n_a_valid), 32'd1);

    // continuous contention: A x8, B x1
    n_b_gnt = 0; n_starved = 0; n_b_valid = 0;
    for (int i = 0; i < 27; i++) step(0, 1, 15'(16'h0400 + i), 1, 15'(16'h0800 + i));
    idle(4);
    chk("t2_b_gnts", 32'(n_b_gnt), 32'd3);
    chk("t2_starved", 32'(n_starved), 32'd3);
    chk("t2_b_valids", 32'(n_b_valid), 32'd3);

    // B alone, 16 back-to-back reads
    n_b_valid = 0; n_starved = 0;
    for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 15'(i));
    idle(4);
    chk("t3_b_valids", 32'(n_b_valid), 32'd16);
    chk("t3_starved", 32'(n_starved), 32'd0);

    // interleaved A/B/A
    step(0, 1, 15'h0100, 0, '0);
    step(0, 0, '0, 1, 15'h0200);
    step(0, 1, 15'h0101, 0, '0);
    idle(4);

    // reset with two reads in flight, then a normal read
    n_a_valid = 0;
    step(0, 1, 15'h0020, 0, '0);
    step(0, 1, 15'h0021, 1, 15'h0022);
    step(1, 1, 15'h0023, 1, 15'h0024);
    idle(4);
    chk("t5_no_valid", 32'(n_a_valid + n_b_valid - 16 - 1), 32'd0);
    step(0, 1, 15'h0030, 0, '0);
    idle(3);
    chk("t5_after_rst", 32'(n_a_valid), 32'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 15'($urandom),
           1'($urandom_range(0, 3) != 0), 15'($urandom));
    idle(4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
